// File: rtl/bit_serial_alu.sv
// bit_serial_alu: one-bit-per-clock ALU with a single full-adder slice and carry flop
module bit_serial_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carryout_o,
    output logic             overflow_o,
    output logic             zero_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cmsb_q, busy_q, done_q, carryout_q, overflow_q, zero_q;
    logic             a_bit, b_bit, b_eff, sum_bit, cout_bit, res_bit, arith, last;
    // Slice datapath: one full-adder bit (B inverted for SUB) or one logic-op bit
    always_comb begin
        a_bit    = a_q[cnt_q];
        b_bit    = b_q[cnt_q];
        b_eff    = b_bit ^ (op_q == 3'b001);
        sum_bit  = a_bit ^ b_eff ^ carry_q;
        cout_bit = (a_bit & b_eff) | (a_bit & carry_q) | (b_eff & carry_q);
        arith    = (op_q[2:1] == 2'b00);
        last     = (cnt_q == CW'(WIDTH - 1));
        res_bit  = arith             ? sum_bit :
                   op_q == 3'b100    ? (a_bit & b_bit) :
                   op_q == 3'b101    ? (a_bit | b_bit) :
                   op_q == 3'b110    ? (a_bit ^ b_bit) :
                   op_q == 3'b111    ? ~(a_bit | b_bit) :
                   op_q == 3'b010    ? ~(a_bit & b_bit) : 1'b0;
    end
    // Control FSM; busy/done trail the state by one cycle so the done pulse is the last busy cycle
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            cmsb_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else if (start_i) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        a_q     <= a_i;
                        b_q     <= b_i;
                        op_q    <= op_i;
                        cnt_q   <= '0;
                        carry_q <= (op_i == 3'b001);
                    end
                end
                RUN: begin
                    result_q[cnt_q] <= res_bit;
                    if (arith) carry_q <= cout_bit;
                    if (last) begin
                        cmsb_q  <= carry_q;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    done_q     <= 1'b1;
                    carryout_q <= arith & carry_q;
                    overflow_q <= arith & (cmsb_q ^ carry_q);
                    zero_q     <= ~|result_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign carryout_o = carryout_q;
    assign overflow_o = overflow_q;
    assign zero_o     = zero_q;
endmodule

// File: tb/tb_bit_serial_alu.sv
// tb_bit_serial_alu: scoreboard bench for the bit-serial ALU at WIDTH=8
module tb_bit_serial_alu;
    localparam int W = 8;
    logic         clk_i = 1'b0, reset_i = 1'b1, start_i = 1'b0;
    logic [2:0]   op_i = '0;
    logic [W-1:0] a_i = '0, b_i = '0;
    logic         busy_o, done_o, carryout_o, overflow_o, zero_o;
    logic [W-1:0] result_o;
    typedef struct packed {logic [W-1:0] r; logic co; logic ov; logic z;} exp_t;
    exp_t sb[$];
    int vectors = 0, miscompares = 0;

    bit_serial_alu #(.WIDTH(W)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o), .carryout_o(carryout_o), .overflow_o(overflow_o),
        .zero_o(zero_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0] s;
        e = '0;
        s = '0;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b};
                e.r = s[W-1:0];
                e.co = s[W];
                e.ov = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            3'b001: begin
                s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                e.r = s[W-1:0];
                e.co = s[W];
                e.ov = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            3'b100: e.r = a & b;
            3'b101: e.r = a | b;
            3'b110: e.r = a ^ b;
            3'b111: e.r = ~(a | b);
            3'b010: e.r = ~(a & b);
            default: e.r = '0;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    // Scoreboard monitor: every done pulse pops one expected result
    always @(posedge clk_i) begin
        exp_t e;
        #1;
        if (done_o) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: got done with empty scoreboard, r=%h", result_o);
            end else begin
                e = sb.pop_front();
                if ({result_o, carryout_o, overflow_o, zero_o} !== e) begin
                    miscompares++;
                    $display("FAIL result: got r=%h co=%b ov=%b z=%b, expected r=%h co=%b ov=%b z=%b",
                             result_o, carryout_o, overflow_o, zero_o, e.r, e.co, e.ov, e.z);
                end
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat, bcnt, dcnt;
        lat = 0; bcnt = 0; dcnt = 0;
        @(negedge clk_i);
        op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        @(posedge clk_i);
        sb.push_back(model(op, a, b));
        #1;
        start_i = 1'b0;
        a_i = W'($urandom); b_i = W'($urandom); op_i = 3'($urandom);
        if (busy_o) bcnt++;
        for (int k = 1; k <= 40 && busy_o; k++) begin
            @(posedge clk_i);
            #1;
            if (busy_o) bcnt++;
            if (done_o) begin dcnt++; lat = k; end
        end
        vectors++;
        if (lat !== W + 1) begin
            miscompares++;
            $display("FAIL latency op=%b: got %0d, expected %0d", op, lat, W + 1);
        end
        vectors++;
        if (bcnt !== W + 2) begin
            miscompares++;
            $display("FAIL busy_cycles op=%b: got %0d, expected %0d", op, bcnt, W + 2);
        end
        vectors++;
        if (dcnt !== 1) begin
            miscompares++;
            $display("FAIL done_pulses op=%b: got %0d, expected 1", op, dcnt);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        vectors++;
        if ({busy_o, done_o, result_o, carryout_o, overflow_o, zero_o} !== {2'b00, 8'h00, 3'b001}) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b r=%h co=%b ov=%b z=%b, expected 0 0 00 0 0 1",
                     busy_o, done_o, result_o, carryout_o, overflow_o, zero_o);
        end
        reset_i = 1'b0;
    endtask

    task automatic test_add();
        run_op(3'b000, 8'h0F, 8'h01);
        run_op(3'b000, 8'hFF, 8'h01);
        run_op(3'b000, 8'h7F, 8'h01);
    endtask

    task automatic test_sub();
        run_op(3'b001, 8'h05, 8'h05);
        run_op(3'b001, 8'h00, 8'h01);
        run_op(3'b001, 8'h80, 8'h01);
    endtask

    task automatic test_logic();
        run_op(3'b110, 8'hA5, 8'hFF);
        run_op(3'b100, 8'hA5, 8'hFF);
        run_op(3'b101, 8'hA5, 8'hFF);
        run_op(3'b111, 8'hA5, 8'hFF);
        run_op(3'b010, 8'hA5, 8'hFF);
        run_op(3'b011, 8'hA5, 8'hFF);
    endtask

    task automatic test_start_while_busy();
        int dcnt;
        dcnt = 0;
        @(negedge clk_i);
        op_i = 3'b000; a_i = 8'h01; b_i = 8'h01; start_i = 1'b1;
        @(posedge clk_i);
        sb.push_back(model(3'b000, 8'h01, 8'h01));
        #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        op_i = 3'b001; a_i = 8'hFF; b_i = 8'h00; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk_i);
            #1;
            if (done_o) dcnt++;
        end
        vectors++;
        if (dcnt !== 1 || sb.size() !== 0) begin
            miscompares++;
            $display("FAIL busy_start: got %0d done pulses, %0d pending, expected 1 and 0", dcnt, sb.size());
        end
    endtask

    task automatic test_reset_mid_op();
        int dcnt;
        dcnt = 0;
        @(negedge clk_i);
        op_i = 3'b000; a_i = 8'h11; b_i = 8'h22; start_i = 1'b1;
        @(posedge clk_i);
        sb.push_back(model(3'b000, 8'h11, 8'h22));
        #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        vectors++;
        if ({busy_o, done_o, result_o, zero_o} !== {2'b00, 8'h00, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_reset: got busy=%b done=%b r=%h z=%b, expected 0 0 00 1",
                     busy_o, done_o, result_o, zero_o);
        end
        sb.delete();
        @(negedge clk_i);
        reset_i = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk_i);
            #1;
            if (done_o || busy_o) dcnt++;
        end
        vectors++;
        if (dcnt !== 0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %0d active cycles, expected 0", dcnt);
        end
        run_op(3'b000, 8'h03, 8'h04);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            logic [2:0] op;
            op = 3'($urandom);
            run_op(op, W'($urandom), W'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        repeat (3) @(posedge clk_i);
        #1;
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
